// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the sequential signed multiply/divide unit:
// default operand width, counter width and FSM state encodings.
package mult_div_unit_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = $clog2(MD_WIDTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MULT_RUN = 3'd1,
    ST_DIV_RUN  = 3'd2,
    ST_DIV_FIX  = 3'd3,
    ST_DONE     = 3'd4,
    ST_DZ       = 3'd5
  } md_state_t;

endpackage

// File: rtl/mult_div_unit_abs.sv
// Two's-complement conditional negation: yields |value| when negate follows the
// sign bit, or a plain sign correction when negate is driven from latched signs.
module mult_div_unit_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result,
  output logic             sign
);

  assign sign   = value[WIDTH-1];
  assign result = negate ? -value : value;

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) and divide (restoring) unit.
// Both algorithms share the accumulator/shift registers; hi/lo load only on DONE.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult,
  input  logic             div,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             dzero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  md_state_t state_reg, state_next;

  // acc_hi is Booth's hi accumulator (one guard bit) or the divide remainder;
  // acc_lo is the multiplier shift register or the dividend/quotient register.
  logic [WIDTH:0]   acc_hi_reg, acc_hi_next;
  logic [WIDTH-1:0] acc_lo_reg, acc_lo_next;
  logic [WIDTH-1:0] opb_reg, opb_next;
  logic             q_m1_reg, q_m1_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             sign_a_reg, sign_a_next;
  logic             sign_b_reg, sign_b_next;

  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic             busy_reg, done_reg, dzero_reg;

  logic [WIDTH-1:0] abs_a_in, abs_b_in, abs_a_out, abs_b_out;
  logic             abs_a_neg, abs_b_neg, abs_a_sign, abs_b_sign;

  logic [WIDTH:0]   opb_ext, booth_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] rem_diff;
  logic             last_step;

  // In IDLE the helpers take operand magnitudes; in DIV_FIX they apply the sign fix.
  always_comb begin
    abs_a_in  = srcA;
    abs_a_neg = srcA[WIDTH-1];
    abs_b_in  = srcB;
    abs_b_neg = srcB[WIDTH-1];
    if (state_reg == ST_DIV_FIX) begin
      abs_a_in  = acc_lo_reg;
      abs_a_neg = sign_a_reg ^ sign_b_reg;
      abs_b_in  = acc_hi_reg[WIDTH-1:0];
      abs_b_neg = sign_a_reg;
    end
  end

  mult_div_unit_abs #(.WIDTH(WIDTH)) u_abs_a (
    .value  (abs_a_in),
    .negate (abs_a_neg),
    .result (abs_a_out),
    .sign   (abs_a_sign)
  );

  mult_div_unit_abs #(.WIDTH(WIDTH)) u_abs_b (
    .value  (abs_b_in),
    .negate (abs_b_neg),
    .result (abs_b_out),
    .sign   (abs_b_sign)
  );

  always_comb begin
    opb_ext = {opb_reg[WIDTH-1], opb_reg};
    case ({acc_lo_reg[0], q_m1_reg})
      2'b01:   booth_sum = acc_hi_reg + opb_ext;
      2'b10:   booth_sum = acc_hi_reg - opb_ext;
      default: booth_sum = acc_hi_reg;
    endcase
  end

  // Remainder stays below the divisor, so its top guard bit is never needed here.
  assign rem_shift = {acc_hi_reg[WIDTH-1:0], acc_lo_reg[WIDTH-1]};
  assign rem_diff  = {1'b0, rem_shift} - {2'b00, opb_reg};
  assign last_step = (cnt_reg == CNT_ONE);

  always_comb begin
    state_next  = state_reg;
    acc_hi_next = acc_hi_reg;
    acc_lo_next = acc_lo_reg;
    opb_next    = opb_reg;
    q_m1_next   = q_m1_reg;
    cnt_next    = cnt_reg;
    sign_a_next = sign_a_reg;
    sign_b_next = sign_b_reg;

    case (state_reg)
      ST_IDLE: begin
        if (mult) begin
          state_next  = ST_MULT_RUN;
          acc_hi_next = '0;
          acc_lo_next = srcA;
          opb_next    = srcB;
          q_m1_next   = 1'b0;
          cnt_next    = CNT_INIT;
        end else if (div) begin
          if (srcB == '0) begin
            state_next = ST_DZ;
          end else begin
            state_next  = ST_DIV_RUN;
            sign_a_next = abs_a_sign;
            sign_b_next = abs_b_sign;
            acc_hi_next = '0;
            acc_lo_next = abs_a_out;
            opb_next    = abs_b_out;
            cnt_next    = CNT_INIT;
          end
        end
      end

      ST_MULT_RUN: begin
        acc_hi_next = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        acc_lo_next = {booth_sum[0], acc_lo_reg[WIDTH-1:1]};
        q_m1_next   = acc_lo_reg[0];
        cnt_next    = cnt_reg - CNT_ONE;
        if (last_step) begin
          state_next = ST_DONE;
        end
      end

      ST_DIV_RUN: begin
        if (!rem_diff[WIDTH+1]) begin
          acc_hi_next = rem_diff[WIDTH:0];
          acc_lo_next = {acc_lo_reg[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi_next = rem_shift;
          acc_lo_next = {acc_lo_reg[WIDTH-2:0], 1'b0};
        end
        cnt_next = cnt_reg - CNT_ONE;
        if (last_step) begin
          state_next = ST_DIV_FIX;
        end
      end

      ST_DIV_FIX: begin
        acc_lo_next = abs_a_out;
        acc_hi_next = {1'b0, abs_b_out};
        state_next  = ST_DONE;
      end

      ST_DONE: state_next = ST_IDLE;
      ST_DZ:   state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_IDLE;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      opb_reg    <= '0;
      q_m1_reg   <= 1'b0;
      cnt_reg    <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      dzero_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      acc_hi_reg <= acc_hi_next;
      acc_lo_reg <= acc_lo_next;
      opb_reg    <= opb_next;
      q_m1_reg   <= q_m1_next;
      cnt_reg    <= cnt_next;
      sign_a_reg <= sign_a_next;
      sign_b_reg <= sign_b_next;
      busy_reg   <= (state_next != ST_IDLE);
      done_reg   <= (state_next == ST_DONE);
      dzero_reg  <= (state_next == ST_DZ);
      // Results become visible together with the done pulse and hold afterwards.
      if (state_next == ST_DONE) begin
        hi_reg <= acc_hi_next[WIDTH-1:0];
        lo_reg <= acc_lo_next;
      end
    end
  end

  assign hi    = hi_reg;
  assign lo    = lo_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;
  assign dzero = dzero_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: expectations come from a behavioural
// 64-bit model, queued at issue and popped when done/dzero appears.
module tb_mult_div_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        mult;
  logic        div;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        dzero;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  logic [31:0] model_hi = 32'h0;
  logic [31:0] model_lo = 32'h0;
  exp_t        sb[$];

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .mult  (mult),
    .div   (div),
    .srcA  (srcA),
    .srcB  (srcB),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done),
    .dzero (dzero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic run_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    exp_t   got;
    longint sa;
    longint sb_v;
    longint p;
    longint q;
    longint r;
    int     cyc;
    string  name;

    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    name = is_mult ? "mult" : "div";
    if (is_mult) begin
      p     = sa * sb_v;
      e.hi  = p[63:32];
      e.lo  = p[31:0];
      e.dz  = 1'b0;
      e.lat = 32;
    end else if (b == 32'h0) begin
      e.hi  = model_hi;
      e.lo  = model_lo;
      e.dz  = 1'b1;
      e.lat = 0;
    end else begin
      q     = sa / sb_v;
      r     = sa % sb_v;
      e.hi  = r[31:0];
      e.lo  = q[31:0];
      e.dz  = 1'b0;
      e.lat = 33;
    end
    model_hi = e.hi;
    model_lo = e.lo;
    sb.push_back(e);

    @(negedge clk);
    mult = is_mult;
    div  = !is_mult;
    srcA = a;
    srcB = b;
    @(posedge clk);
    #1;
    mult = 1'b0;
    div  = 1'b0;
    srcA = $urandom;
    srcB = $urandom;
    cyc  = 0;
    check({name, "_busy_start"}, 64'(busy), 64'(1));
    while (!done && !dzero && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    got = sb.pop_front();
    check({name, "_latency"}, 64'(cyc), 64'(got.lat));
    check({name, "_dzero"}, 64'(dzero), 64'(got.dz));
    check({name, "_done"}, 64'(done), 64'(!got.dz));
    check({name, "_hi"}, 64'(hi), 64'(got.hi));
    check({name, "_lo"}, 64'(lo), 64'(got.lo));
    @(posedge clk);
    #1;
    check({name, "_done_pulse"}, 64'(done), 64'(0));
    check({name, "_dzero_pulse"}, 64'(dzero), 64'(0));
    check({name, "_idle"}, 64'(busy), 64'(0));
    check({name, "_hi_hold"}, 64'(hi), 64'(got.hi));
    check({name, "_lo_hold"}, 64'(lo), 64'(got.lo));
    $display("op=%s a=%h b=%h hi=%h lo=%h lat=%0d dzero=%0b", name, a, b, hi, lo, cyc, got.dz);
  endtask

  initial begin
    reset = 1'b0;
    mult  = 1'b0;
    div   = 1'b0;
    srcA  = 32'h0;
    srcB  = 32'h0;
    #12;
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dzero", 64'(dzero), 64'(0));
    @(negedge clk);
    reset = 1'b1;

    run_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFD);
    run_op(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000);
    run_op(1'b0, 32'hFFFF_FFF9, 32'h0000_0002);
    run_op(1'b0, 32'h0000_0007, 32'hFFFF_FFFE);
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      run_op(1'b1, $urandom, $urandom);
      run_op(1'b0, $urandom, $urandom_range(1, 32'h0001_FFFF));
    end
    run_op(1'b0, 32'h0000_0005, 32'h0000_0002);
    run_op(1'b0, 32'h0000_0005, 32'h0000_0000);

    // A divide request mid-multiply must be ignored; then reset aborts the multiply.
    @(negedge clk);
    mult = 1'b1;
    srcA = 32'h1234_5678;
    srcB = 32'h0000_0009;
    @(posedge clk);
    #1;
    mult = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    div  = 1'b1;
    srcB = 32'h0;
    @(posedge clk);
    #1;
    div = 1'b0;
    check("ignored_div_dzero", 64'(dzero), 64'(0));
    check("ignored_div_busy", 64'(busy), 64'(1));
    check("ignored_div_hi", 64'(hi), 64'(model_hi));
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    model_hi = 32'h0;
    model_lo = 32'h0;
    $display("op=abort reset mid-multiply hi=%h lo=%h busy=%0b", hi, lo, busy);
    @(negedge clk);
    reset = 1'b1;

    run_op(1'b1, 32'h0000_0003, 32'h0000_0004);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
